// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, ID branch operand,
// mult/div occupancy and data-memory wait hazards, plus HI/LO unit sequencing.
//
// state  | meaning
// S_IDLE | mult/div unit free, a new start may be accepted
// S_BUSY | mult/div in flight, r_cnt counts down remaining cycles
module pipeline_hazard_controller #(
  parameter int MD_CYCLES = 32,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_branch,
  input  logic       id_branch_taken,
  input  logic       id_md_start,
  input  logic       id_md_read,
  input  logic       ex_reg_write,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_mem_to_reg,
  input  logic [4:0] mem_write_reg,
  input  logic       dmem_wait,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_md_busy;
  logic          r_md_done;

  logic w_freeze, w_ex_match, w_mem_match, w_lu, w_br, w_mdh, w_hz, w_md_start;

  // A write to $0 never creates a dependency, so matches require a nonzero destination.
  assign w_ex_match  = (ex_write_reg != 5'd0) &&
                       ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
  assign w_mem_match = (mem_write_reg != 5'd0) &&
                       ((mem_write_reg == id_rs) || (mem_write_reg == id_rt));

  assign w_freeze   = dmem_wait;
  assign w_lu       = ex_mem_to_reg && w_ex_match;
  assign w_br       = id_branch && ((ex_reg_write && w_ex_match) ||
                                    (mem_mem_to_reg && w_mem_match));
  assign w_mdh      = (r_state == S_BUSY) && (id_md_start || id_md_read);
  assign w_hz       = w_lu || w_br || w_mdh;
  assign w_md_start = !rst && id_md_start && (r_state == S_IDLE) && !w_hz && !w_freeze;

  assign stall_pc    = !rst && (w_freeze || w_hz);
  assign stall_ifid  = !rst && (w_freeze || w_hz);
  assign stall_idex  = !rst && w_freeze;
  assign stall_exmem = !rst && w_freeze;
  assign flush_idex  = !rst && w_hz && !w_freeze;
  assign flush_ifid  = !rst && id_branch && id_branch_taken && !w_hz && !w_freeze;
  assign md_start    = w_md_start;
  assign md_busy     = r_md_busy && !rst;
  assign md_done     = r_md_done && !rst;

  // The countdown ignores pipeline freeze: the unit runs independently of stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_md_start) begin
            r_state   <= S_BUSY;
            r_cnt     <= CW'(MD_CYCLES - 1);
            r_md_busy <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus random checks of pipeline_hazard_controller against a
// cycle-number model of the mult/div unit and the hazard rules.
module tb_pipeline_hazard_controller;
  localparam int MD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic       id_branch, id_branch_taken, id_md_start, id_md_read;
  logic       ex_reg_write, ex_mem_to_reg, mem_mem_to_reg, dmem_wait;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, md_start, md_busy, md_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_start = 0;
  bit have_op = 0;

  pipeline_hazard_controller #(.MD_CYCLES(MD), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch),
    .id_branch_taken(id_branch_taken), .id_md_start(id_md_start),
    .id_md_read(id_md_read), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg(mem_write_reg),
    .dmem_wait(dmem_wait),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_in();
    rst = 0; id_rs = 0; id_rt = 0; id_branch = 0; id_branch_taken = 0;
    id_md_start = 0; id_md_read = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_write_reg = 0; mem_mem_to_reg = 0; mem_write_reg = 0; dmem_wait = 0;
  endtask

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && (r == id_rs || r == id_rt);
  endfunction

  // Inputs are driven at the falling edge; outputs are checked 2 time units later.
  task automatic tick();
    bit busy, done, lu, br, mdh, hz, fz, e_start;
    #2;
    busy = have_op && cyc >= s_start + 1 && cyc <= s_start + MD;
    done = have_op && cyc == s_start + MD + 1;
    fz   = dmem_wait;
    lu   = ex_mem_to_reg && uses(ex_write_reg);
    br   = id_branch && ((ex_reg_write && uses(ex_write_reg)) ||
                         (mem_mem_to_reg && uses(mem_write_reg)));
    mdh  = busy && (id_md_start || id_md_read);
    hz   = lu || br || mdh;
    e_start = id_md_start && !busy && !hz && !fz;
    if (rst) begin
      fz = 0; hz = 0; busy = 0; done = 0; e_start = 0;
    end
    chk("stall_pc",    stall_pc,    fz || hz);
    chk("stall_ifid",  stall_ifid,  fz || hz);
    chk("stall_idex",  stall_idex,  fz);
    chk("stall_exmem", stall_exmem, fz);
    chk("flush_idex",  flush_idex,  hz && !fz);
    chk("flush_ifid",  flush_ifid,  !rst && id_branch && id_branch_taken && !hz && !fz);
    chk("md_start",    md_start,    e_start);
    chk("md_busy",     md_busy,     busy);
    chk("md_done",     md_done,     done);
    if (rst) have_op = 0;
    else if (e_start) begin
      have_op = 1;
      s_start = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    rst = 1;
    @(negedge clk);
    tick();
    id_branch = 1; id_branch_taken = 1; dmem_wait = 1; id_md_start = 1;
    tick();
    clear_in();
    tick();

    // load-use, then $0 never matches
    ex_mem_to_reg = 1; ex_write_reg = 8; id_rs = 8;
    tick();
    clear_in(); id_rs = 8;
    tick();
    clear_in(); ex_mem_to_reg = 1; ex_write_reg = 0; id_rs = 0;
    tick();

    // branch after ALU op
    clear_in(); id_branch = 1; id_branch_taken = 1;
    ex_reg_write = 1; ex_write_reg = 9; id_rt = 9;
    tick();
    ex_reg_write = 0; ex_write_reg = 0; mem_write_reg = 9;
    tick();

    // branch after load: EX match, MEM-load match, then resolve
    clear_in(); id_branch = 1; id_branch_taken = 1; id_rs = 10;
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg = 10;
    tick();
    ex_reg_write = 0; ex_mem_to_reg = 0; ex_write_reg = 0;
    mem_mem_to_reg = 1; mem_write_reg = 10;
    tick();
    mem_mem_to_reg = 0; mem_write_reg = 0;
    tick();

    // mult then mflo held until done
    clear_in(); id_md_start = 1;
    tick();
    clear_in(); id_md_read = 1;
    for (int i = 0; i < 5; i++) tick();
    clear_in();
    tick();

    // freeze while busy with a load-use pending
    id_md_start = 1;
    tick();
    clear_in(); dmem_wait = 1; ex_mem_to_reg = 1; ex_write_reg = 5; id_rt = 5;
    for (int i = 0; i < 3; i++) tick();
    clear_in();
    for (int i = 0; i < 3; i++) tick();

    // reset mid-operation, new mult accepted right after
    id_md_start = 1;
    tick();
    clear_in();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; id_md_start = 1;
    tick();
    clear_in();
    for (int i = 0; i < 6; i++) tick();

    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 59) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_branch       = 1'($urandom_range(0, 3) == 0);
      id_branch_taken = 1'($urandom);
      id_md_start     = 1'($urandom_range(0, 3) == 0);
      id_md_read      = 1'($urandom_range(0, 3) == 0);
      ex_reg_write    = 1'($urandom);
      ex_mem_to_reg   = 1'($urandom_range(0, 3) == 0);
      ex_write_reg    = 5'($urandom_range(0, 3));
      mem_mem_to_reg  = 1'($urandom_range(0, 3) == 0);
      mem_write_reg   = 5'($urandom_range(0, 3));
      dmem_wait       = 1'($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. It complements the EX-stage forwarding logic by covering every hazard that forwarding cannot resolve.
- Hazards covered: load-use, ID-stage branch operand dependency, multi-cycle mult/div occupancy, and data-memory wait.
- Drives the PC and pipeline-register enables and flushes. Owns the busy/done sequencing of the shared HI/LO mult/div unit.

Parameters:
MD_CYCLES, 32, mult/div latency in cycles from accepted start to result valid (legal range 2..63)
CW, 6, counter width; must satisfy 2^CW > MD_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
id_rs  input  5  source register rs of instruction in ID
id_rt  input  5  source register rt of instruction in ID
id_branch  input  1  ID instruction is beq/bne (operands compared in ID)
id_branch_taken  input  1  branch comparator result in ID
id_md_start  input  1  ID instruction is mult/multu/div/divu
id_md_read  input  1  ID instruction is mfhi/mflo
ex_reg_write  input  1  EX instruction writes register file
ex_mem_to_reg  input  1  EX instruction is a load
ex_write_reg  input  5  EX destination register
mem_mem_to_reg  input  1  MEM instruction is a load
mem_write_reg  input  5  MEM destination register
dmem_wait  input  1  data memory not ready this cycle
stall_pc  output  1  hold PC
stall_ifid  output  1  hold IF/ID register
stall_idex  output  1  hold ID/EX register
stall_exmem  output  1  hold EX/MEM register
flush_ifid  output  1  clear IF/ID to nop
flush_idex  output  1  insert bubble into ID/EX
md_start  output  1  one-cycle start strobe to the mult/div unit
md_busy  output  1  registered, mult/div unit in flight
md_done  output  1  registered, one-cycle pulse when HI/LO valid

Behaviour:
- Reset: state IDLE, counter 0, md_busy=0, md_done=0. While rst=1, all outputs are 0.
- Register $0 never causes a dependency. Every match term below requires the compared register to be nonzero.
- freeze = dmem_wait.
  - Effect: stall_pc = stall_ifid = stall_idex = stall_exmem = 1.
  - No flush and no md_start while frozen. freeze has highest priority.
- lu (load-use) = ex_mem_to_reg and ex_write_reg matches id_rs or id_rt.
- br = id_branch and either:
  - ex_reg_write with ex_write_reg matching rs or rt, or
  - mem_mem_to_reg with mem_write_reg matching rs or rt.
- mdh = state BUSY and (id_md_start or id_md_read).
- hz = lu or br or mdh. When hz and not freeze: stall_pc = stall_ifid = 1, flush_idex = 1, stall_idex = stall_exmem = 0.
- flush_ifid = id_branch and id_branch_taken and not hz and not freeze. The branch resolves only on the cycle its operands are clean.
- md_start = id_md_start and state IDLE and not hz and not freeze. Combinational; asserted exactly once per accepted instruction.
- FSM (2 states):
  - IDLE -> BUSY on md_start. Counter loads MD_CYCLES-1 and md_busy becomes 1 next cycle.
  - BUSY: counter decrements every cycle, including during freeze; the unit is independent of pipeline stalls.
  - BUSY with counter=0 -> IDLE. Next cycle md_busy=0 and md_done=1 for exactly one cycle.
  - A new md_start is possible the cycle after returning to IDLE. Back-to-back issue spacing is MD_CYCLES+1.
- Reset mid-operation aborts the mult/div sequence: state IDLE, no md_done pulse.
- All stall/flush outputs are combinational from inputs and state. md_busy and md_done are registered.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_write_reg=8, id_rs=8 -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1. With id_rs=0 and ex_write_reg=0 -> no stall.
- Branch after ALU op: id_branch=1, ex_reg_write=1, ex_write_reg=9, id_rt=9, taken=1 -> cycle 1 stall and flush_idex with flush_ifid=0. Next cycle, with the dependency now in MEM as a non-load -> flush_ifid=1 and no stall.
- Branch after load: ex load to $10 and branch on $10 -> 2 stall cycles (EX match, then MEM-load match), then flush_ifid=1 if taken.
- Mult/div latency with MD_CYCLES=4: mult in ID at cycle 0 -> md_start=1 at cycle 0, md_busy=1 for cycles 1-4, md_done=1 at cycle 5. An mflo in ID during cycles 1-4 stalls; it is released at cycle 5.
- Freeze: dmem_wait=1 for 3 cycles while BUSY and lu is true -> all four stall outputs =1 and both flush outputs =0 for those 3 cycles; the counter still decrements and md_done timing is unchanged.
- Reset mid-op: assert rst 2 cycles after md_start -> md_busy=0 next cycle, no md_done. The next mult is accepted immediately after rst deasserts.
